// File: rtl/audio_pkg.sv
// Shared definitions for the audio streaming blocks on axis_clk.
// Packet geometry, frame timing and the arbiter state encoding.
package audio_pkg;

  localparam int AUD_WORDS_PER_PKT = 2;
  localparam int I2S_FRAME_CYCLES  = 512;
  localparam int GRANT_W           = 2;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    SIL_L,
    SIL_R
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Pure combinational round-robin picker: the first requester at or after ptr+1, with wrap.
// Has no state, so any fan-in or fan-out block can reuse it with its own pointer register.
module rr_arbiter_comb #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // NOTE: every output gets a default before the search, so no path infers a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      for (int i = 0; i < N; i++) begin
        if (!any && (i == cand) && req[i]) begin
          any       = 1'b1;
          onehot[i] = 1'b1;
          idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axis_audio_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC AXIS audio producers onto the I2S TX port.
// Inserts a silence L/R packet when no producer delivers within one I2S frame.
module axis_audio_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int DATA_W       = 32,
  parameter int SILENCE_EN   = 1,
  parameter int IDLE_TIMEOUT = I2S_FRAME_CYCLES
) (
  input  logic                      axis_clk,
  input  logic                      axis_reset,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  input  logic [NUM_SRC-1:0]        s_valid,
  input  logic [NUM_SRC-1:0]        s_last,
  output logic [NUM_SRC-1:0]        s_ready,
  input  logic [NUM_SRC-1:0]        src_enable,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [GRANT_W-1:0]        grant_idx,
  output logic                      silence_active
);

  localparam int                CNT_W   = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_t          state_q;
  logic [GRANT_W-1:0]  grant_q;
  logic [GRANT_W-1:0]  ptr_q;
  logic [NUM_SRC-1:0]  grant_oh_q;
  logic [CNT_W-1:0]    idle_cnt_q;

  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  arb_onehot;
  logic [GRANT_W-1:0]  arb_idx;
  logic                arb_any;

  // Enable is only looked at here, so it gates new grants but never a packet in flight.
  assign req = s_valid & src_enable;

  rr_arbiter_comb #(
    .N     (NUM_SRC),
    .IDX_W (GRANT_W)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axis_clk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ptr_q      <= GRANT_W'(NUM_SRC - 1);
      grant_oh_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q    <= arb_idx;
            ptr_q      <= arb_idx;
            grant_oh_q <= arb_onehot;
            idle_cnt_q <= '0;
            state_q    <= FWD;
          end else if ((SILENCE_EN != 0) && (idle_cnt_q == CNT_MAX)) begin
            idle_cnt_q <= '0;
            state_q    <= SIL_L;
          end else if (idle_cnt_q != CNT_MAX) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        FWD: begin
          if (m_valid && m_ready && m_last) state_q <= IDLE;
        end
        SIL_L: begin
          if (m_ready) state_q <= SIL_R;
        end
        SIL_R: begin
          if (m_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // m_valid depends only on state and the granted source, never on m_ready.
  always_comb begin
    m_data         = '0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    s_ready        = '0;
    silence_active = 1'b0;
    case (state_q)
      FWD: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_q == GRANT_W'(i)) begin
            m_data  = s_data[i*DATA_W +: DATA_W];
            m_valid = s_valid[i];
            m_last  = s_last[i];
          end
        end
        s_ready = grant_oh_q & {NUM_SRC{m_ready}};
      end
      SIL_L: begin
        m_valid        = 1'b1;
        silence_active = 1'b1;
      end
      SIL_R: begin
        m_valid        = 1'b1;
        m_last         = 1'b1;
        silence_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_idx = grant_q;

endmodule

// File: tb/tb_axis_audio_arbiter.sv
// Directed bench for axis_audio_arbiter: two queued sources, an always-ready-or-stalled sink,
// and a second instance with silence disabled that must stay quiet while idle.
module tb_axis_audio_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DATA_W  = 32;

  logic                      axis_clk = 1'b0;
  logic                      axis_reset;
  logic [NUM_SRC*DATA_W-1:0] s_data;
  logic [NUM_SRC-1:0]        s_valid;
  logic [NUM_SRC-1:0]        s_last;
  logic [NUM_SRC-1:0]        s_ready;
  logic [NUM_SRC-1:0]        src_enable;
  logic [DATA_W-1:0]         m_data;
  logic                      m_valid;
  logic                      m_last;
  logic                      m_ready;
  logic [1:0]                grant_idx;
  logic                      silence_active;

  logic [NUM_SRC-1:0]        s_ready_q;
  logic [DATA_W-1:0]         m_data_q;
  logic                      m_valid_q;
  logic                      m_last_q;
  logic [1:0]                grant_idx_q;
  logic                      silence_active_q;

  always #5 axis_clk = ~axis_clk;

  axis_audio_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SILENCE_EN(1), .IDLE_TIMEOUT(512)
  ) dut (
    .axis_clk(axis_clk), .axis_reset(axis_reset), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .src_enable(src_enable), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .grant_idx(grant_idx),
    .silence_active(silence_active)
  );

  axis_audio_arbiter #(
    .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .SILENCE_EN(0), .IDLE_TIMEOUT(512)
  ) dut_quiet (
    .axis_clk(axis_clk), .axis_reset(axis_reset), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready_q), .src_enable(src_enable), .m_data(m_data_q),
    .m_valid(m_valid_q), .m_last(m_last_q), .m_ready(m_ready), .grant_idx(grant_idx_q),
    .silence_active(silence_active_q)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  gidx;
    logic        sil;
  } beat_t;

  beat_t       log_q[$];
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [1:0]  hs;
  int          errors = 0;
  int          checks = 0;

  logic        snap_valid, snap_last, snap_sil, snap_valid2;
  logic [31:0] snap_data;
  logic [1:0]  snap_ready, snap_gidx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic l, input logic [1:0] g,
                               input logic s);
    beat_t b;
    b.data = d; b.last = l; b.gidx = g; b.sil = s;
    return b;
  endfunction

  function automatic beat_t beat_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return '0;
  endfunction

  task automatic refresh();
    s_valid[0]     = (q0.size() != 0);
    s_last[0]      = (q0.size() != 0) ? q0[0][32] : 1'b0;
    s_data[31:0]   = (q0.size() != 0) ? q0[0][31:0] : 32'h0;
    s_valid[1]     = (q1.size() != 0);
    s_last[1]      = (q1.size() != 0) ? q1[0][32] : 1'b0;
    s_data[63:32]  = (q1.size() != 0) ? q1[0][31:0] : 32'h0;
  endtask

  task automatic push0(input logic [31:0] d, input logic l);
    q0.push_back({l, d});
  endtask

  task automatic push1(input logic [31:0] d, input logic l);
    q1.push_back({l, d});
  endtask

  // One clock: sample everything mid-cycle, then advance the sources just after the edge.
  task automatic step();
    @(negedge axis_clk);
    hs          = s_valid & s_ready;
    snap_valid  = m_valid;
    snap_last   = m_last;
    snap_data   = m_data;
    snap_ready  = s_ready;
    snap_gidx   = grant_idx;
    snap_sil    = silence_active;
    snap_valid2 = m_valid_q;
    if (m_valid && m_ready) log_q.push_back(mk(m_data, m_last, grant_idx, silence_active));
    @(posedge axis_clk);
    #1;
    if (!axis_reset) begin
      if (hs[0]) void'(q0.pop_front());
      if (hs[1]) void'(q1.pop_front());
    end
    refresh();
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int k = 0; k < budget && log_q.size() < n; k++) step();
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    q0.delete();
    q1.delete();
    log_q.delete();
    m_ready    = 1'b1;
    src_enable = 2'b11;
    refresh();
    repeat (2) @(posedge axis_clk);
    #1;
    axis_reset = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input int i, input beat_t exp);
    check(tag, 64'(beat_at(i)), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_valid;
    logic first_sil;
    int quiet_cnt;

    axis_reset = 1'b1;
    m_ready    = 1'b1;
    src_enable = 2'b11;
    push0(32'h000077, 1'b1);
    refresh();
    repeat (2) @(posedge axis_clk);
    #1;
    check("rst_m", 64'({m_valid, m_last, m_data}), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_gidx", 64'(grant_idx), 64'(0));
    check("rst_sil", 64'(silence_active), 64'(0));

    // Single source, single packet
    do_reset();
    push0(32'h000123, 1'b0);
    push0(32'h000456, 1'b1);
    refresh();
    step();
    check("t1_arb_latency", 64'(snap_valid), 64'(0));
    wait_log(2, 20);
    check("t1_count", 64'(log_q.size()), 64'(2));
    expect_beat("t1_L", 0, mk(32'h000123, 1'b0, 2'd0, 1'b0));
    expect_beat("t1_R", 1, mk(32'h000456, 1'b1, 2'd0, 1'b0));

    // Both sources continuously valid: strict alternation, no interleaving
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push0(32'(32'h100 + 2*p), 1'b0);
      push0(32'(32'h101 + 2*p), 1'b1);
      push1(32'(32'h200 + 2*p), 1'b0);
      push1(32'(32'h201 + 2*p), 1'b1);
    end
    refresh();
    wait_log(12, 100);
    check("t2_count", 64'(log_q.size()), 64'(12));
    for (int i = 0; i < 12; i++) begin
      int pkt, src, w;
      pkt = i / 2; src = pkt % 2; w = i % 2;
      expect_beat($sformatf("t2_beat%0d", i), i,
                  mk(32'((src != 0 ? 32'h200 : 32'h100) + 2*(pkt/2) + w), w[0], src[1:0], 1'b0));
    end

    // Sink stalls for 10 cycles after the L word
    do_reset();
    push0(32'h000AAA, 1'b0);
    push0(32'h000BBB, 1'b1);
    push1(32'h000CCC, 1'b0);
    push1(32'h000DDD, 1'b1);
    refresh();
    wait_log(1, 20);
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("t3_hold%0d", k), 64'({snap_valid, snap_last, snap_data}),
            64'({1'b1, 1'b1, 32'h000BBB}));
      check($sformatf("t3_ready%0d", k), 64'(snap_ready), 64'(0));
    end
    m_ready = 1'b1;
    wait_log(4, 20);
    expect_beat("t3_R", 1, mk(32'h000BBB, 1'b1, 2'd0, 1'b0));
    expect_beat("t3_src1_L", 2, mk(32'h000CCC, 1'b0, 2'd1, 1'b0));
    expect_beat("t3_src1_R", 3, mk(32'h000DDD, 1'b1, 2'd1, 1'b0));

    // Idle timeout produces exactly one silence packet; the quiet instance stays silent
    do_reset();
    first_valid = -1;
    first_sil   = 1'b0;
    quiet_cnt   = 0;
    for (int n = 1; n <= 530; n++) begin
      step();
      if (snap_valid && first_valid < 0) begin
        first_valid = n;
        first_sil   = snap_sil;
      end
      if (snap_valid2) quiet_cnt++;
    end
    check("t4_timeout_cycle", 64'(first_valid), 64'(513));
    check("t4_sil_flag", 64'(first_sil), 64'(1));
    check("t4_count", 64'(log_q.size()), 64'(2));
    expect_beat("t4_sil_L", 0, mk(32'h0, 1'b0, 2'd0, 1'b1));
    expect_beat("t4_sil_R", 1, mk(32'h0, 1'b1, 2'd0, 1'b1));
    check("t4_quiet_valid", 64'(quiet_cnt), 64'(0));

    // Enable masking; dropping the enable mid-packet still completes the packet
    do_reset();
    src_enable = 2'b01;
    push0(32'h000510, 1'b0);
    push0(32'h000511, 1'b1);
    push0(32'h000512, 1'b0);
    push0(32'h000513, 1'b1);
    push1(32'h000520, 1'b0);
    push1(32'h000521, 1'b1);
    refresh();
    wait_log(1, 20);
    src_enable = 2'b00;
    wait_log(2, 20);
    expect_beat("t5_L", 0, mk(32'h000510, 1'b0, 2'd0, 1'b0));
    expect_beat("t5_R", 1, mk(32'h000511, 1'b1, 2'd0, 1'b0));
    repeat (20) step();
    check("t5_disabled_count", 64'(log_q.size()), 64'(2));
    src_enable = 2'b01;
    wait_log(4, 20);
    expect_beat("t5_pkt2_L", 2, mk(32'h000512, 1'b0, 2'd0, 1'b0));
    expect_beat("t5_pkt2_R", 3, mk(32'h000513, 1'b1, 2'd0, 1'b0));
    src_enable = 2'b11;
    wait_log(6, 20);
    expect_beat("t5_src1_L", 4, mk(32'h000520, 1'b0, 2'd1, 1'b0));
    expect_beat("t5_src1_R", 5, mk(32'h000521, 1'b1, 2'd1, 1'b0));

    // Reset mid-packet: outputs clear at once, src0 wins next, src1 remnant becomes a 1-word packet
    do_reset();
    push1(32'h000333, 1'b0);
    push1(32'h000444, 1'b1);
    refresh();
    wait_log(1, 20);
    check("t6_gidx_before", 64'(snap_gidx), 64'(1));
    axis_reset = 1'b1;
    #1;
    check("t6_rst_m", 64'({m_valid, m_last, m_data}), 64'(0));
    check("t6_rst_ready", 64'(s_ready), 64'(0));
    check("t6_rst_gidx", 64'(grant_idx), 64'(0));
    push0(32'h000111, 1'b0);
    push0(32'h000222, 1'b1);
    refresh();
    @(posedge axis_clk);
    #1;
    axis_reset = 1'b0;
    step();
    check("t6_no_stray", 64'(snap_valid), 64'(0));
    wait_log(4, 30);
    expect_beat("t6_src0_L", 1, mk(32'h000111, 1'b0, 2'd0, 1'b0));
    expect_beat("t6_src0_R", 2, mk(32'h000222, 1'b1, 2'd0, 1'b0));
    expect_beat("t6_src1_R", 3, mk(32'h000444, 1'b1, 2'd1, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
